// File: rtl/fsmd_divider.sv
// Multi-cycle restoring divider: 8-bit dividend / 4-bit divisor, one quotient bit per cycle.
// A start/done handshake lets a controlling FSM sequence it behind the multiply datapath.
module fsmd_divider (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [3:0] divisor,
    output logic [7:0] quotient,
    output logic [3:0] remainder,
    output logic       busy,
    output logic       done,
    output logic       div_by_zero,
    output logic [2:0] PS
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DIV  = 3'd1,
        S_DONE = 3'd2
    } state_t;

    state_t     state_reg;
    logic [4:0] p_reg;
    logic [7:0] dsr_reg;
    logic [7:0] qsr_reg;
    logic [3:0] dvs_reg;
    logic [2:0] count_reg;

    logic [4:0] trial_next;
    logic       fits_next;
    logic [4:0] p_next;
    logic [7:0] q_next;

    // The partial remainder always stays below the divisor after an iteration,
    // so its top bit and the quotient MSB shifted out are never consumed.
    logic [1:0] unused_bits;
    assign unused_bits = {p_reg[4], qsr_reg[7]};

    always_comb begin
        trial_next = {p_reg[3:0], dsr_reg[7]};
        fits_next  = (trial_next >= {1'b0, dvs_reg});
        p_next     = fits_next ? (trial_next - {1'b0, dvs_reg}) : trial_next;
        q_next     = {qsr_reg[6:0], fits_next};
    end

    assign PS = state_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            p_reg       <= 5'd0;
            dsr_reg     <= 8'd0;
            qsr_reg     <= 8'd0;
            dvs_reg     <= 4'd0;
            count_reg   <= 3'd0;
            quotient    <= 8'd0;
            remainder   <= 4'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        dvs_reg   <= divisor;
                        dsr_reg   <= dividend;
                        p_reg     <= 5'd0;
                        qsr_reg   <= 8'd0;
                        count_reg <= 3'd0;
                        busy      <= 1'b1;
                        if (divisor == 4'd0) begin
                            // Saturated quotient flags the fault without a DIV pass.
                            quotient    <= 8'hFF;
                            remainder   <= 4'd0;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state_reg   <= S_DONE;
                        end else begin
                            state_reg <= S_DIV;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_DIV: begin
                    p_reg     <= p_next;
                    qsr_reg   <= q_next;
                    dsr_reg   <= {dsr_reg[6:0], 1'b0};
                    count_reg <= count_reg + 3'd1;
                    if (count_reg == 3'd7) begin
                        quotient    <= q_next;
                        remainder   <= p_next[3:0];
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        state_reg   <= S_DONE;
                    end
                end
                S_DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsmd_divider.sv
// Scoreboard bench for fsmd_divider: stimulus pushes expected results, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_fsmd_divider;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;
    logic [2:0] PS;

    fsmd_divider dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .PS          (PS)
    );

    always #5 clock = ~clock;

    typedef struct {
        int dd;
        int dv;
        int q;
        int r;
        int z;
        int due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   done_seen = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (!reset && done) begin
            done_seen++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done with q=%0d r=%0d, expected no done", quotient, remainder);
            end else begin
                mon_e = sb.pop_front();
                $display("div %0d / %0d -> q=%0d r=%0d dbz=%0d", mon_e.dd, mon_e.dv, quotient, remainder, div_by_zero);
                check("quotient", int'(quotient), mon_e.q);
                check("remainder", int'(remainder), mon_e.r);
                check("div_by_zero", int'(div_by_zero), mon_e.z);
                check("done_cycle", cyc, mon_e.due);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (PS != 3'd0 && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (PS != 3'd0) check("idle_timeout", int'(PS), 0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    endtask

    // Called on a negedge; returns on the negedge after the accept edge E0.
    task automatic issue(input int dd, input int dv, input int q, input int r, input int z);
        exp_t e;
        wait_idle();
        start    = 1'b1;
        dividend = 8'(dd);
        divisor  = 4'(dv);
        e.dd = dd; e.dv = dv; e.q = q; e.r = r; e.z = z;
        e.due = cyc + 1 + ((dv == 0) ? 0 : 8);
        sb.push_back(e);
        @(negedge clock);
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
    endtask

    task automatic pulse_start(input int dd, input int dv);
        start    = 1'b1;
        dividend = 8'(dd);
        divisor  = 4'(dv);
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_PS"}, int'(PS), 0);
        check({tag, "_quotient"}, int'(quotient), 0);
        check({tag, "_remainder"}, int'(remainder), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_dbz"}, int'(div_by_zero), 0);
    endtask

    initial begin
        int d0;
        int cnt;
        int n;

        reset    = 1'b1;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 4'd0;
        repeat (2) @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clock);

        // 143 / 11: busy for exactly 9 cycles, one done pulse.
        d0 = done_seen;
        issue(143, 11, 13, 0, 0);
        cnt = 0;
        n   = 0;
        while (busy && n < 30) begin
            cnt++;
            @(negedge clock);
            n++;
        end
        check("busy_cycles", cnt, 9);
        check("done_pulses_143", done_seen - d0, 1);

        issue(200, 7, 28, 4, 0);
        issue(255, 1, 255, 0, 0);
        issue(5, 9, 0, 5, 0);
        issue(90, 0, 255, 0, 1);
        issue(100, 10, 10, 0, 0);

        // Extra starts during DIV and DONE are ignored.
        wait_drain();
        d0 = done_seen;
        issue(225, 15, 15, 0, 0);
        repeat (3) @(negedge clock);
        pulse_start(16, 2);
        n = 0;
        while (!done && n < 30) begin
            @(negedge clock);
            n++;
        end
        check("done_seen_225", int'(done), 1);
        pulse_start(16, 2);
        repeat (12) @(negedge clock);
        check("done_pulses_225", done_seen - d0, 1);
        check("idle_after_225", int'(PS), 0);

        // Asynchronous reset at E4 aborts without a done pulse.
        wait_drain();
        wait_idle();
        d0 = done_seen;
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 4'd7;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1 reset = 1'b1;
        #1 check_reset_outputs("abort");
        @(negedge clock);
        reset = 1'b0;
        repeat (12) @(negedge clock);
        check("done_pulses_abort", done_seen - d0, 0);
        issue(200, 7, 28, 4, 0);

        // Back-to-back sweep of every dividend against every non-zero divisor.
        for (int dd = 0; dd < 256; dd++) begin
            for (int dv = 1; dv < 16; dv++) begin
                issue(dd, dv, dd / dv, dd % dv, 0);
            end
        end
        wait_drain();
        repeat (3) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
